// File: rtl/move_asteroides_responder.sv
// -----------------------------------------------------------------------------
// move_asteroides_responder
//
// Responder side of the coordinator's "move asteroids" start/done handshake.
// A one-cycle start pulse launches one pass over every slot of the asteroid
// RAM. Each slot is read (synchronous RAM, one cycle of latency). If the slot is
// valid it is moved one step along its direction and written back. An
// asteroid that would leave the grid is written back with its valid bit cleared
// and its coordinates unchanged. At the end of the pass a one-cycle done pulse
// is issued, and the number of asteroids still active is registered.
//
// Entry packing (dado_lido / dado_escrita): {valido, dir[2:0], x, y}
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   iniciar       start pulse from the coordinator
//   dado_lido     RAM read data, valid the cycle after end_mem is presented
//   end_mem       RAM address
//   escreve_mem   RAM write enable
//   dado_escrita  RAM write data
//   ocupado       high while a pass is in progress (any state but OCIOSO)
//   fim_move      one-cycle done pulse
//   qtd_ativos    active asteroids counted in the last pass
//   db_estado     current state code, for debug
// -----------------------------------------------------------------------------
module move_asteroides_responder #(
    parameter int N_ASTEROIDES = 16,
    parameter int LARG_COORD   = 4,
    parameter int LARG_END     = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      iniciar,
    input  logic [3+2*LARG_COORD:0]   dado_lido,
    output logic [LARG_END-1:0]       end_mem,
    output logic                      escreve_mem,
    output logic [3+2*LARG_COORD:0]   dado_escrita,
    output logic                      ocupado,
    output logic                      fim_move,
    output logic [LARG_END:0]         qtd_ativos,
    output logic [2:0]                db_estado
);

    localparam int LARG_ENTRADA = 4 + 2*LARG_COORD;

    localparam logic [LARG_END-1:0] ULTIMO   = LARG_END'(N_ASTEROIDES - 1);
    localparam logic [LARG_END-1:0] UM_END   = LARG_END'(1);
    localparam logic [LARG_END:0]   UM_CONT  = (LARG_END+1)'(1);
    localparam logic [LARG_COORD:0] UM_COORD = (LARG_COORD+1)'(1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LE      = 3'd1,
        ESPERA  = 3'd2,
        ESCREVE = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t               estado;
    logic [LARG_END-1:0]   indice;
    logic [LARG_END:0]     contador;

    // Fields of the entry currently on the read bus.
    logic                  lido_valido;
    logic [2:0]            lido_dir;
    logic [LARG_COORD-1:0] lido_x;
    logic [LARG_COORD-1:0] lido_y;

    assign lido_valido = dado_lido[LARG_ENTRADA-1];
    assign lido_dir    = dado_lido[LARG_ENTRADA-2 -: 3];
    assign lido_x      = dado_lido[2*LARG_COORD-1 -: LARG_COORD];
    assign lido_y      = dado_lido[LARG_COORD-1:0];

    // One step computed with an extra bit: stepping below 0 wraps to all ones
    // and stepping past the top reaches 2^LARG_COORD, so in both cases the
    // extra MSB is set. That single bit therefore flags "left the grid".
    logic [LARG_COORD:0]       novo_x;
    logic [LARG_COORD:0]       novo_y;
    logic                      fora;
    logic [LARG_ENTRADA-1:0]   movido;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the case statements can infer a latch.
    always_comb begin
        novo_x = {1'b0, lido_x};
        novo_y = {1'b0, lido_y};
        case (lido_dir)
            3'd1, 3'd2, 3'd3: novo_x = novo_x + UM_COORD;
            3'd5, 3'd6, 3'd7: novo_x = novo_x - UM_COORD;
            default:          ;
        endcase
        case (lido_dir)
            3'd0, 3'd1, 3'd7: novo_y = novo_y - UM_COORD;
            3'd3, 3'd4, 3'd5: novo_y = novo_y + UM_COORD;
            default:          ;
        endcase
        fora   = novo_x[LARG_COORD] | novo_y[LARG_COORD];
        movido = fora ? {1'b0, lido_dir, lido_x, lido_y}
                      : {1'b1, lido_dir, novo_x[LARG_COORD-1:0], novo_y[LARG_COORD-1:0]};
    end

    assign db_estado = estado;

    // Outputs are registered: each transition loads the output values of the
    // state being entered. The entry latched in ESPERA is held directly in
    // dado_escrita (already moved), and escreve_mem holds its read valid bit.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: the async reset clears every register, including the write enable,
    // so no RAM write can occur while reset_n is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= OCIOSO;
            indice       <= '0;
            contador     <= '0;
            qtd_ativos   <= '0;
            end_mem      <= '0;
            escreve_mem  <= 1'b0;
            dado_escrita <= '0;
            ocupado      <= 1'b0;
            fim_move     <= 1'b0;
        end else begin
            escreve_mem  <= 1'b0;
            dado_escrita <= '0;
            fim_move     <= 1'b0;
            case (estado)
                OCIOSO: begin
                    end_mem <= '0;
                    if (iniciar) begin
                        estado   <= LE;
                        indice   <= '0;
                        contador <= '0;
                        ocupado  <= 1'b1;
                    end else begin
                        ocupado  <= 1'b0;
                    end
                end
                LE: begin
                    estado  <= ESPERA;
                    end_mem <= indice;
                    ocupado <= 1'b1;
                end
                ESPERA: begin
                    estado  <= ESCREVE;
                    end_mem <= indice;
                    ocupado <= 1'b1;
                    // Invalid slots are neither written nor counted.
                    if (lido_valido) begin
                        escreve_mem  <= 1'b1;
                        dado_escrita <= movido;
                    end
                end
                ESCREVE: begin
                    ocupado <= 1'b1;
                    if (escreve_mem && dado_escrita[LARG_ENTRADA-1])
                        contador <= contador + UM_CONT;
                    if (indice == ULTIMO) begin
                        estado   <= FIM;
                        end_mem  <= '0;
                        fim_move <= 1'b1;
                    end else begin
                        estado   <= LE;
                        indice   <= indice + UM_END;
                        end_mem  <= indice + UM_END;
                    end
                end
                FIM: begin
                    estado     <= OCIOSO;
                    qtd_ativos <= contador;
                    end_mem    <= '0;
                    ocupado    <= 1'b0;
                end
                default: begin
                    estado  <= OCIOSO;
                    end_mem <= '0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/move_asteroides_responder.md
Name: move_asteroides_responder

Overview:
- Responder side of the coordinator's "move asteroids" start/done handshake.
- On a one-cycle start pulse, walks every asteroid slot in the asteroid RAM (synchronous read, 1-cycle latency) and applies one step along each slot's direction.
- Clears the valid bit of any asteroid that would leave the grid.
- Reports completion with a one-cycle done pulse plus a count of still-active asteroids.

Parameters:
- N_ASTEROIDES, default 16: number of slots in asteroid RAM; must be a power of 2 and at least 2.
- LARG_COORD, default 4: bit width of each coordinate; grid is 0..2^LARG_COORD-1 per axis.
- LARG_END, default 4: address width, equal to log2(N_ASTEROIDES).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- iniciar  in  1  start pulse from coordinator (sinal_movimenta_asteroides)
- dado_lido  in  3+1+2*LARG_COORD  RAM read data {valido, dir[2:0], x, y}; valid the cycle after end_mem is presented
- end_mem  out  LARG_END  RAM address
- escreve_mem  out  1  RAM write enable
- dado_escrita  out  3+1+2*LARG_COORD  RAM write data, same packing as dado_lido
- ocupado  out  1  high in every state except OCIOSO
- fim_move  out  1  one-cycle done pulse (fim_move_asteroides)
- qtd_ativos  out  LARG_END+1  valid asteroids after last pass, registered
- db_estado  out  3  current state code

Behaviour:
- Reset (reset_n low, at any time, including mid-pass): state OCIOSO, slot index 0, latched entry 0, qtd_ativos 0, active counter 0. All outputs 0. No RAM write may occur while reset_n is low.
- Moore FSM, state codes:
  - OCIOSO=0: iniciar=1 moves to LE; index:=0, active counter:=0.
  - LE=1: end_mem=index; always moves to ESPERA.
  - ESPERA=2: end_mem=index; latches dado_lido into the entry register at the clock edge; moves to ESCREVE.
  - ESCREVE=3: end_mem=index.
    - escreve_mem=1 only if the latched valido=1.
    - Writes the moved entry.
    - Increments the active counter if the written valido=1.
    - index==N_ASTEROIDES-1 moves to FIM; otherwise index+1 and moves to LE.
  - FIM=4: fim_move=1; qtd_ativos loads the active counter (visible from the next cycle); moves to OCIOSO.
- Outputs not listed above are 0 in the given state. end_mem=0 in OCIOSO and FIM. Codes 5-7 are illegal and go to OCIOSO.
- Latency: start sampled at edge k gives fim_move high in cycle k+3*N_ASTEROIDES+1 (49 for N=16). The next start is accepted in the cycle after FIM.
- iniciar is ignored in every state except OCIOSO, and a pulse arriving mid-pass is not queued. iniciar held high causes back-to-back passes with one OCIOSO cycle between them.
- Move rule, with y increasing downward:
  - dir 0: (0,-1)
  - dir 1: (+1,-1)
  - dir 2: (+1,0)
  - dir 3: (+1,+1)
  - dir 4: (0,+1)
  - dir 5: (-1,+1)
  - dir 6: (-1,0)
  - dir 7: (-1,-1)
- Compute the move at LARG_COORD+1 bits. If either result is below 0 or above 2^LARG_COORD-1:
  - write valido=0, keeping x, y and dir unchanged (no wrap-around);
  - the slot does not count as active.
  - Otherwise write valido=1, the new x and y, and the same dir.
- Invalid slots (valido=0): not written and not counted.
- Corner case: moves on both axes that exit on both axes are handled by the same single invalidation.
- Address wrap: index never exceeds N_ASTEROIDES-1, and the pass ends exactly at the last slot.

Test Plan:
- Reset mid-pass: pulse iniciar, assert reset_n=0 during the 5th ESCREVE → state 0, escreve_mem=0, fim_move never pulses. After release, a new iniciar completes a normal pass.
- Single asteroid: slot 3={1,dir2,x=5,y=7}, all others invalid, iniciar at edge k:
  - exactly one write, at addr 3, with {1,2,6,7};
  - fim_move high at cycle k+49;
  - qtd_ativos=1.
- Boundary exit: slot 0={1,dir7,x=0,y=4} and slot 1={1,dir4,x=9,y=15}:
  - both written with valido=0 and coordinates unchanged;
  - qtd_ativos=0.
- All directions: 8 valid asteroids at (8,8) with dirs 0..7 → written positions (8,7),(9,7),(9,8),(9,9),(8,9),(7,9),(7,8),(7,7); qtd_ativos=8.
- Handshake robustness: iniciar re-pulsed during ESPERA of slot 6 → ignored, a single fim_move pulse. iniciar held high for 120 cycles → two complete passes, with fim_move pulses 50 cycles apart.
- Full RAM: all 16 slots valid at (1,1) dir 3 → 16 writes to (2,2), qtd_ativos=16 (tests the LARG_END+1 width).
